// File: rtl/encode_rr_prio.sv
// Registered N-to-index encoder with fixed-priority or round-robin selection among
// active request lines; the result is held under a valid/ready handshake.
module encode_rr_prio #(
  parameter int N    = 8,
  parameter int W    = $clog2(N),
  parameter bit HL   = 1'b1,
  parameter bit MODE = 1'b0
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         EN,
  input  logic [N-1:0] IN,
  input  logic         READY,
  output logic [W-1:0] OUT,
  output logic         VALID,
  output logic         MULTI
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  state_t       state_q, state_d;
  logic [W-1:0] idx_q, idx_d;
  logic [W-1:0] ptr_q, ptr_d;
  logic         multi_q, multi_d;
  logic [W-1:0] start_s;
  logic [W-1:0] win_s;
  logic [W:0]   nxt_s;
  logic         load_s;

  function automatic logic [W-1:0] lowest_set(input logic [N-1:0] v);
    logic [W-1:0] r;
    r = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (v[i]) r = W'(i);
    end
    return r;
  endfunction

  // Rotate so that line 'start' sits at bit 0, pick the lowest, then undo the rotation mod N.
  function automatic logic [W-1:0] rr_pick(input logic [N-1:0] req, input logic [W-1:0] start);
    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [W:0]     sum;
    dbl = {req, req} >> start;
    rot = dbl[N-1:0];
    sum = {1'b0, start} + {1'b0, lowest_set(rot)};
    if (sum >= (W+1)'(N)) begin
      sum = sum - (W+1)'(N);
    end
    return sum[W-1:0];
  endfunction

  // Next-state: capture, hold, or release the stored result.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    multi_d = multi_q;
    ptr_d   = ptr_q;
    if (MODE) begin
      start_s = ptr_q;
    end else begin
      start_s = '0;
    end
    win_s  = rr_pick(IN, start_s);
    nxt_s  = {1'b0, win_s} + {{W{1'b0}}, 1'b1};
    load_s = EN && (|IN) && ((state_q == IDLE) || READY);
    if (load_s) begin
      state_d = HOLD;
      idx_d   = win_s;
      multi_d = |(IN & (IN - ONE));
      if (nxt_s == (W+1)'(N)) begin
        ptr_d = '0;
      end else begin
        ptr_d = nxt_s[W-1:0];
      end
    end else if ((state_q == HOLD) && READY) begin
      state_d = IDLE;
    end else begin
      state_d = state_q;
    end
  end

  // State registers; reset discards any pending result.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      idx_q   <= '0;
      ptr_q   <= '0;
      multi_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      multi_q <= multi_d;
    end
  end

  assign OUT   = HL ? idx_q : ~idx_q;
  assign VALID = (state_q == HOLD);
  assign MULTI = multi_q;

endmodule
